csr_file: RTL

Machine-mode CSR file and trap responder for the 5-stage RV64 pipeline. It consumes the CSR control bundle (`csr_control_t`) of the instruction committing in writeback and services it:
- CSR read/modify/write
- exception and interrupt entry
- `mret`

It returns the old CSR value for register writeback, emits a registered one-cycle PC redirect that flushes the pipeline, and reports enabled pending interrupts to fetch so the next fetched instruction is tagged `INTERUPT`.

---
 rtl/csr_file.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file and trap responder for the RV64 pipeline.
//
// Services the CSR control bundle of the instruction committing in writeback:
// CSR read/modify/write, exception and interrupt entry, and mret. Returns the
// pre-update CSR value for register writeback, issues a registered one-cycle
// PC redirect (pipeline flush), and reports enabled pending interrupts to fetch.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   req_valid         committing instruction carries a valid CSR bundle
//   req_ctype         NONE / EXCEPTION / INTERUPT / RET / CSR_INSTR
//   req_op            CSRRW / CSRRC / CSRRS
//   req_imm           1 = source is req_zimm, 0 = source is req_rs1
//   req_csra          CSR address
//   req_zimm          5-bit immediate source (zero-extended)
//   req_rs1           rs1 source value
//   req_code          exception/interrupt cause code
//   req_pc            PC of the committing instruction
//   irq               {trint, swint, exint}, level-sensitive
//   rdata             combinational pre-update value of req_csra
//   redirect_valid    registered one-cycle redirect pulse
//   redirect_pc       redirect target, valid with redirect_valid
//   pending_int       mstatus.MIE & |(mip & mie)
//   int_code          highest-priority pending enabled interrupt (11 > 3 > 7), 0 if none
module csr_file #(
    parameter logic [63:0] RESET_MTVEC = 64'h0,
    parameter logic [63:0] HARTID      = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_ctype,
    input  logic [1:0]  req_op,
    input  logic        req_imm,
    input  logic [11:0] req_csra,
    input  logic [4:0]  req_zimm,
    input  logic [63:0] req_rs1,
    input  logic [3:0]  req_code,
    input  logic [63:0] req_pc,
    input  logic [2:0]  irq,
    output logic [63:0] rdata,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        pending_int,
    output logic [3:0]  int_code
);

    localparam logic [2:0] CtNone      = 3'd0;
    localparam logic [2:0] CtException = 3'd1;
    localparam logic [2:0] CtInterupt  = 3'd2;
    localparam logic [2:0] CtRet       = 3'd3;
    localparam logic [2:0] CtCsrInstr  = 3'd4;

    localparam logic [1:0] OpRw = 2'd0;
    localparam logic [1:0] OpRc = 2'd1;
    localparam logic [1:0] OpRs = 2'd2;

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMie      = 12'h304;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMscratch = 12'h340;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMip      = 12'h344;
    localparam logic [11:0] AddrMcycle   = 12'hB00;
    localparam logic [11:0] AddrMhartid  = 12'hF14;

    localparam logic [63:0] MieMask = 64'h888;

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [63:0] r_mie;
    logic [63:0] r_mtvec;
    logic [63:0] r_mscratch;
    logic [63:0] r_mepc;
    logic [63:0] r_mcause;
    logic [63:0] r_mip;
    logic [63:0] r_mcycle;
    logic        r_redirect_valid;
    logic [63:0] r_redirect_pc;

    logic [63:0] w_mstatus;
    logic [63:0] w_rdata;
    logic [63:0] w_src;
    logic [63:0] w_wdata;
    logic [63:0] w_mip_d;
    logic [63:0] w_int_en;
    logic        w_accept;
    logic        w_csr_wr;
    logic        w_trap;
    logic        w_ret;
    logic        w_redirect_d;
    logic [63:0] w_redirect_pc_d;

    // Read mux; also the "old" operand for set/clear.
    always_comb begin
        // MPP is hardwired to machine mode.
        w_mstatus = {51'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
        w_rdata   = 64'b0;
        case (req_csra)
            AddrMstatus:  w_rdata = w_mstatus;
            AddrMie:      w_rdata = r_mie;
            AddrMtvec:    w_rdata = r_mtvec;
            AddrMscratch: w_rdata = r_mscratch;
            AddrMepc:     w_rdata = r_mepc;
            AddrMcause:   w_rdata = r_mcause;
            AddrMip:      w_rdata = r_mip;
            AddrMcycle:   w_rdata = r_mcycle;
            AddrMhartid:  w_rdata = HARTID;
            default:      w_rdata = 64'b0;
        endcase
    end

    assign rdata = w_rdata;

    // Modify stage of read/modify/write.
    always_comb begin
        w_src   = req_imm ? {59'b0, req_zimm} : req_rs1;
        w_wdata = w_rdata;
        case (req_op)
            OpRw:    w_wdata = w_src;
            OpRs:    w_wdata = w_rdata | w_src;
            OpRc:    w_wdata = w_rdata & ~w_src;
            default: w_wdata = w_rdata;
        endcase
    end

    always_comb begin
        w_mip_d     = 64'b0;
        w_mip_d[11] = irq[0];
        w_mip_d[3]  = irq[1];
        w_mip_d[7]  = irq[2];
    end

    // Requests seen while a redirect is out belong to squashed instructions.
    always_comb begin
        w_accept        = req_valid && !r_redirect_valid;
        w_csr_wr        = 1'b0;
        w_trap          = 1'b0;
        w_ret           = 1'b0;
        w_redirect_d    = 1'b0;
        w_redirect_pc_d = r_redirect_pc;
        if (w_accept) begin
            case (req_ctype)
                CtCsrInstr: begin
                    w_csr_wr        = 1'b1;
                    w_redirect_d    = 1'b1;
                    w_redirect_pc_d = req_pc + 64'd4;
                end
                CtException, CtInterupt: begin
                    w_trap          = 1'b1;
                    w_redirect_d    = 1'b1;
                    w_redirect_pc_d = {r_mtvec[63:2], 2'b00};
                end
                CtRet: begin
                    w_ret           = 1'b1;
                    w_redirect_d    = 1'b1;
                    w_redirect_pc_d = r_mepc;
                end
                CtNone:  ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mstatus_mie    <= 1'b0;
            r_mstatus_mpie   <= 1'b0;
            r_mie            <= 64'b0;
            r_mtvec          <= RESET_MTVEC;
            r_mscratch       <= 64'b0;
            r_mepc           <= 64'b0;
            r_mcause         <= 64'b0;
            r_mip            <= 64'b0;
            r_mcycle         <= 64'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 64'b0;
        end else begin
            r_mip            <= w_mip_d;
            r_redirect_valid <= w_redirect_d;
            r_redirect_pc    <= w_redirect_pc_d;

            // A software write to mcycle wins over the increment.
            if (w_csr_wr && req_csra == AddrMcycle) begin
                r_mcycle <= w_wdata;
            end else begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (w_csr_wr) begin
                case (req_csra)
                    AddrMstatus: begin
                        r_mstatus_mie  <= w_wdata[3];
                        r_mstatus_mpie <= w_wdata[7];
                    end
                    AddrMie:      r_mie      <= w_wdata & MieMask;
                    AddrMtvec:    r_mtvec    <= w_wdata;
                    AddrMscratch: r_mscratch <= w_wdata;
                    AddrMepc:     r_mepc     <= {w_wdata[63:2], 2'b00};
                    AddrMcause:   r_mcause   <= w_wdata;
                    default:      ;
                endcase
            end

            if (w_trap) begin
                r_mepc         <= req_pc;
                r_mcause       <= {(req_ctype == CtInterupt), 59'b0, req_code};
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end

            if (w_ret) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

    // Fixed priority: external > software > timer.
    always_comb begin
        w_int_en    = r_mip & r_mie;
        pending_int = r_mstatus_mie && (w_int_en != 64'b0);
        int_code    = 4'd0;
        if (pending_int) begin
            if (w_int_en[11]) begin
                int_code = 4'd11;
            end else if (w_int_en[3]) begin
                int_code = 4'd3;
            end else begin
                int_code = 4'd7;
            end
        end
    end

endmodule
